// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generator, single-cycle memory interface
// and a credit-limited instruction queue toward decode, with redirect and halt.
module fetch_unit #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0000_0000,
    parameter int unsigned                DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic                  instr_ready_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  pc_q;
    logic                   inflight_q;
    logic [DATA_WIDTH-1:0]  inflight_pc_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [DATA_WIDTH-1:0]  instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  pc_mem    [DEPTH];

    logic                   has_credit;
    logic [CNT_W:0]         occupancy;
    logic                   issue, pop, wr;
    logic                   unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Credit counts the in-flight slot too, so a response always has room.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign has_credit = occupancy < (CNT_W+1)'(DEPTH);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i)  state_d = HALT;
            HALT:    if (!halt_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req_o    = (state_q == RUN) && has_credit && !redirect_valid_i;
        instr_valid_o = (count_q != '0) && !redirect_valid_i;
    end

    assign issue       = imem_req_o;
    assign pop         = instr_valid_o && instr_ready_i;
    assign wr          = inflight_q && !redirect_valid_i;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_mem[rd_ptr_q];
    assign pc_o        = pc_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else if (redirect_valid_i) begin
            pc_q       <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + DATA_WIDTH'(4);
                inflight_pc_q <= pc_q;
            end
            if (wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst_n(arst_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .halt_i(halt_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .instr_ready_i(instr_ready_i)
    );

    // Reference model: mode 0=booting, 1=fetching, 2=halted
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    bit          m_infl;
    logic [31:0] m_infl_pc, m_pc;
    int          m_mode;

    int checks = 0, errors = 0;
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl = 0; m_infl_pc = '0; m_pc = RST_PC; m_mode = 0;
    endtask

    task automatic step();
        bit e_req, e_valid;
        #2;
        e_req   = (m_mode == 1) && (mq.size() + int'(m_infl) < DEPTH) && !redirect_valid_i;
        e_valid = (mq.size() != 0) && !redirect_valid_i;
        chk("imem_req", 32'(imem_req_o), 32'(e_req));
        chk("imem_addr", imem_addr_o, m_pc);
        chk("instr_valid", 32'(instr_valid_o), 32'(e_valid));
        if (e_valid) begin
            chk("pc_o", pc_o, mq[0].pc);
            chk("instr_o", instr_o, mq[0].instr);
        end
        obs_req = imem_req_o; obs_addr = imem_addr_o; obs_valid = instr_valid_o;
        obs_pc = pc_o; obs_instr = instr_o;
        @(posedge clk); #1;
        if (redirect_valid_i) begin
            mq.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
            m_infl = 0;
        end else begin
            if (e_valid && instr_ready_i) void'(mq.pop_front());
            if (m_infl) mq.push_back('{m_infl_pc, m_infl_pc ^ KEY});
            if (e_req) begin
                m_infl = 1; m_infl_pc = m_pc; m_pc = m_pc + 32'd4;
            end else m_infl = 0;
        end
        case (m_mode)
            0: m_mode = 1;
            1: if (halt_i) m_mode = 2;
            default: if (!halt_i) m_mode = 1;
        endcase
        imem_rdata_i = obs_req ? (obs_addr ^ KEY) : $urandom();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_addr", imem_addr_o, RST_PC);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        redirect_valid_i = 0; halt_i = 0;
        arst_n = 1'b1;
    endtask

    typedef struct {
        bit redir; logic [31:0] rpc; bit halt; bit ready;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nreq, found;
        logic [31:0] last_addr, first_addr;

        tbl[0] = '{0, 0, 0, 1, 0, 32'h0,  0, 32'h0};
        tbl[1] = '{0, 0, 0, 1, 1, 32'h0,  0, 32'h0};
        tbl[2] = '{0, 0, 0, 1, 1, 32'h4,  0, 32'h0};
        tbl[3] = '{0, 0, 0, 1, 1, 32'h8,  1, 32'h0};
        tbl[4] = '{0, 0, 0, 1, 1, 32'hC,  1, 32'h4};
        tbl[5] = '{0, 0, 0, 1, 1, 32'h10, 1, 32'h8};

        model_reset();
        #2;
        do_reset();

        // Basic fetch latency and throughput
        for (int i = 0; i < 6; i++) begin
            redirect_valid_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc;
            halt_i = tbl[i].halt; instr_ready_i = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_req", i), 32'(obs_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(obs_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), obs_instr, tbl[i].e_pc ^ KEY);
            end
        end

        // Queue fills with decode stalled, then drains in order
        do_reset();
        instr_ready_i = 0; nreq = 0; last_addr = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_req) begin nreq++; last_addr = obs_addr; end
        end
        chk("fill_req_count", 32'(nreq), 32'd4);
        chk("fill_last_addr", last_addr, 32'hC);
        instr_ready_i = 1; first_addr = 'x; found = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_valid", 32'(obs_valid), 32'd1);
            chk("drain_pc", obs_pc, 32'(i * 4));
            if (obs_req && found == 0) begin found = 1; first_addr = obs_addr; end
        end
        chk("drain_resume_addr", first_addr, 32'h10);

        // Redirect with two queued entries and one in flight
        do_reset();
        instr_ready_i = 0;
        repeat (4) step();
        redirect_valid_i = 1; redirect_pc_i = 32'h103;
        step();
        chk("redir_valid", 32'(obs_valid), 32'd0);
        chk("redir_req", 32'(obs_req), 32'd0);
        redirect_valid_i = 0; instr_ready_i = 1;
        step();
        chk("redir_next_addr", obs_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            step();
            if (obs_valid) begin found = 1; chk("redir_first_pc", obs_pc, 32'h100); end
        end
        chk("redir_delivered", 32'(found), 32'd1);

        // Halt for five cycles while decode keeps draining
        repeat (4) step();
        halt_i = 1; nreq = 0; last_addr = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0 && obs_req) last_addr = obs_addr;
            if (i > 0 && obs_req) nreq++;
        end
        chk("halt_reqs", 32'(nreq), 32'd0);
        chk("halt_drained", 32'(obs_valid), 32'd0);
        halt_i = 0; found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            step();
            if (obs_req) begin found = 1; chk("halt_resume_addr", obs_addr, last_addr + 32'd4); end
        end
        chk("halt_resumed", 32'(found), 32'd1);

        // Reset pulse while the queue holds three entries
        do_reset();
        instr_ready_i = 0;
        repeat (5) step();
        chk("midrst_pre_valid", 32'(obs_valid), 32'd1);
        do_reset();
        instr_ready_i = 1;
        step();
        step();
        chk("midrst_first_req", 32'(obs_req), 32'd1);
        chk("midrst_first_addr", obs_addr, RST_PC);
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            step();
            if (obs_valid) begin found = 1; chk("midrst_first_pc", obs_pc, RST_PC); end
        end
        chk("midrst_delivered", 32'(found), 32'd1);

        // Address wrap-around at the top of the space
        redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFE;
        step();
        redirect_valid_i = 0;
        step();
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", obs_addr, 32'h0);
        repeat (4) step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt_i = ~halt_i;
            redirect_valid_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                        : $urandom();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port arst_n  input  1  asynchronous, active-low reset.
REQ-006 Port redirect_valid_i  input  1  branch/jump redirect from the execute-stage control-flow unit.
REQ-007 Port redirect_pc_i  input  DATA_WIDTH  redirect target address.
REQ-008 Port halt_i  input  1  suspend new fetches.
REQ-009 Port imem_req_o  output  1  instruction memory read request.
REQ-010 Port imem_addr_o  output  DATA_WIDTH  request address.
REQ-011 Port imem_rdata_i  input  DATA_WIDTH  read data, valid exactly one cycle after an accepted request.
REQ-012 Port instr_valid_o  output  1  queue head valid toward decode.
REQ-013 Port instr_o  output  DATA_WIDTH  queue head instruction.
REQ-014 Port pc_o  output  DATA_WIDTH  PC of the queue head instruction.
REQ-015 Port instr_ready_i  input  1  decode accepts head; pop when instr_valid_o and instr_ready_i are both high.

Function
REQ-016 FSM states: BOOT, RUN, HALT. Transitions: BOOT -> RUN on first edge after reset release; RUN -> HALT when halt_i=1; HALT -> RUN when halt_i=0.
REQ-017 pc_q holds the next fetch address; imem_addr_o = pc_q.
REQ-018 imem_req_o = (state==RUN) and (count + inflight_q < DEPTH) and not redirect_valid_i; combinational.
REQ-019 On an issued request: pc_q <= pc_q + 4 (mod 2^DATA_WIDTH); inflight_q <= 1 with its PC captured; otherwise inflight_q <= 0.
REQ-020 Cycle after an issue: imem_rdata_i and the captured PC are written into the queue at the end of that cycle, unless redirect_valid_i is high in that cycle.
REQ-021 Queue is FIFO; head drives instr_o/pc_o directly; instr_valid_o = (count != 0) and not redirect_valid_i.
REQ-022 Write and pop in the same cycle: count unchanged, both take effect; read/write pointers wrap modulo DEPTH.
REQ-023 The credit rule in REQ-018 guarantees no write when full; pop in the same cycle does not grant extra credit.
REQ-024 Redirect cycle: queue flushed (count <= 0, pointers reset), in-arriving response dropped, no issue, no pop, pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
REQ-025 Redirect has priority over pop, write, issue, and halt; redirect in HALT updates pc_q and flushes but state stays HALT.
REQ-026 In HALT: no issue; an in-flight response is still written; queue still drains to decode.
REQ-027 Fetch-to-decode latency: request in cycle k -> instr_valid_o with that instruction in cycle k+2 if the queue was empty.
REQ-028 With instr_ready_i held high and no redirect or halt: one request and one instruction delivered per cycle in steady state.

Reset
REQ-029 On arst_n low, immediately: state=BOOT, pc_q=RESET_PC, count=0, pointers=0, inflight_q=0; outputs imem_req_o=0, instr_valid_o=0.
REQ-030 Reset asserted mid-operation discards queue contents and any in-flight response; the response arriving after release is ignored.
REQ-031 Queue storage data need not be reset; instr_o/pc_o are don't-care while instr_valid_o=0.

Verification
REQ-032 Reset release, ready=1, memory returns addr^32'hA5A5_0000 -> req at 0x0 in cycle 1, 0x4 in cycle 2; instr_valid_o=1, pc_o=0x0, instr_o=32'hA5A5_0000 in cycle 3; one instruction per cycle thereafter.
REQ-033 ready=0 from reset -> exactly 4 requests (0x0-0xC), then imem_req_o=0; ready=1 -> pc_o 0x0,0x4,0x8,0xC in order, fetching resumes at 0x10.
REQ-034 redirect_valid_i=1, redirect_pc_i=0x103 in a cycle with 2 queued and 1 in flight -> instr_valid_o=0 that cycle, queue empty, next req at 0x100, first delivered pc_o=0x100; no stale PC ever appears.
REQ-035 halt_i=1 for 5 cycles with ready=1 -> no requests during halt, in-flight instruction still delivered, queue drains to empty; halt_i=0 -> fetch resumes at next sequential PC.
REQ-036 arst_n pulsed low while queue holds 3 entries -> outputs 0 immediately; after release, first req at RESET_PC, first pc_o=RESET_PC.
REQ-037 pc_q=0xFFFF_FFFC issued -> next address 0x0000_0000 (wrap-around).
